// File: rtl/mem_stage_if.sv
// EX -> MEM pipeline bundle: instruction fields from EX plus the MEM
// stage's allow-in handshake back to EX.
interface mem_stage_if;
  logic        to_mem_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_alu_result;
  logic        ex_is_load;
  logic [2:0]  ex_load_op;
  logic [7:0]  ex_exc;
  logic        mem_allow_in;

  // EX side drives the instruction and observes allow-in.
  modport master (
    output to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result,
           ex_is_load, ex_load_op, ex_exc,
    input  mem_allow_in
  );

  // MEM side consumes the instruction and produces allow-in.
  modport slave (
    input  to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result,
           ex_is_load, ex_load_op, ex_exc,
    output mem_allow_in
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX instruction, waits for the data-SRAM
// load response, aligns load data and hands the result to WB.
// Optional macro MEM_ALE_CHECK_EN adds a load address-alignment exception.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ex,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_data_ok,
  input  logic        wb_allow_in,
  input  logic        flush,
  output logic        mem_to_wb_valid,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [3:0]  mem_rf_we,
  output logic [4:0]  mem_rf_waddr,
  output logic [31:0] mem_rf_wdata,
  output logic [7:0]  mem_exc,
  output logic        mem_load_pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no response outstanding for this stage
    WAIT  = 2'd1,  // held load is waiting for its response
    DRAIN = 2'd2   // load was flushed; swallow its late response
  } state_e;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  state_e      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  load_op_q, load_op_d;
  logic [7:0]  exc_q, exc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_captured_q, data_captured_d;

  logic        ale;
  logic [7:0]  ex_exc_eff;
  logic        ready_go;
  logic        allow_in;
  logic        accept;
  logic        load_waits;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

`ifdef MEM_ALE_CHECK_EN
  // Misaligned LW / LH / LHU raise ale (bit 2) as the instruction enters.
  always_comb begin
    ale = ex.ex_is_load &&
          (((ex.ex_load_op == OP_LW) && (ex.ex_alu_result[1:0] != 2'b00)) ||
           (((ex.ex_load_op == OP_LH) || (ex.ex_load_op == OP_LHU)) &&
            ex.ex_alu_result[0]));
  end
`else
  assign ale = 1'b0;
`endif

  assign ex_exc_eff = ex.ex_exc | {5'b0_0000, ale, 2'b00};

  // An excepting load never waits: it goes to WB to raise its exception.
  assign ready_go   = !is_load_q || data_captured_q || (exc_q != 8'h00);
  assign allow_in   = (state_q != DRAIN) &&
                      (!mem_valid_q || (ready_go && wb_allow_in));
  assign accept     = ex.to_mem_valid && allow_in && !flush;
  assign load_waits = ex.ex_is_load && (ex_exc_eff == 8'h00);

  // Response tracking FSM: next state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && load_waits && !data_sram_data_ok) state_d = WAIT;
      WAIT:    if (data_sram_data_ok)  state_d = IDLE;
               else if (flush)         state_d = DRAIN;
      DRAIN:   if (data_sram_data_ok)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage occupancy, instruction latch and load-data capture.
  always_comb begin
    mem_valid_d     = mem_valid_q;
    pc_d            = pc_q;
    rf_we_d         = rf_we_q;
    rf_waddr_d      = rf_waddr_q;
    alu_result_d    = alu_result_q;
    is_load_d       = is_load_q;
    load_op_d       = load_op_q;
    exc_d           = exc_q;
    rdata_d         = rdata_q;
    data_captured_d = data_captured_q;

    if (flush)         mem_valid_d = 1'b0;
    else if (allow_in) mem_valid_d = ex.to_mem_valid;

    if (accept) begin
      pc_d            = ex.ex_pc;
      rf_we_d         = ex.ex_rf_we;
      rf_waddr_d      = ex.ex_rf_waddr;
      alu_result_d    = ex.ex_alu_result;
      is_load_d       = ex.ex_is_load;
      load_op_d       = ex.ex_load_op;
      exc_d           = ex_exc_eff;
      data_captured_d = 1'b0;
      // Response may arrive in the very cycle the load moves into MEM.
      if (load_waits && data_sram_data_ok) begin
        rdata_d         = data_sram_rdata;
        data_captured_d = 1'b1;
      end
    end else if ((state_q == WAIT) && data_sram_data_ok) begin
      rdata_d         = data_sram_rdata;
      data_captured_d = 1'b1;
    end
  end

  // Load alignment: pick byte / half by the low address bits and extend.
  always_comb begin
    case (alu_result_q[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = alu_result_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (load_op_q)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h00_0000, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0000, ld_half};
      default: load_data = rdata_q;
    endcase
  end

  // State register; everything visible to WB resets to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      mem_valid_q     <= 1'b0;
      pc_q            <= '0;
      rf_we_q         <= '0;
      rf_waddr_q      <= '0;
      alu_result_q    <= '0;
      is_load_q       <= 1'b0;
      load_op_q       <= '0;
      exc_q           <= '0;
      rdata_q         <= '0;
      data_captured_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q         <= state_d;
      mem_valid_q     <= mem_valid_d;
      pc_q            <= pc_d;
      rf_we_q         <= rf_we_d;
      rf_waddr_q      <= rf_waddr_d;
      alu_result_q    <= alu_result_d;
      is_load_q       <= is_load_d;
      load_op_q       <= load_op_d;
      exc_q           <= exc_d;
      rdata_q         <= rdata_d;
      data_captured_q <= data_captured_d;
    end
  end

  assign ex.mem_allow_in   = allow_in;
  assign mem_to_wb_valid   = mem_valid_q && ready_go && !flush;
  assign mem_valid         = mem_valid_q;
  assign mem_pc            = pc_q;
  assign mem_rf_we         = rf_we_q;
  assign mem_rf_waddr      = rf_waddr_q;
  assign mem_rf_wdata      = is_load_q ? load_data : alu_result_q;
  assign mem_exc           = exc_q;
  assign mem_load_pending  = mem_valid_q && !ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the stage.
// Honors MEM_ALE_CHECK_EN the same way the design does.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        wb_allow_in;
  logic        flush;
  logic        mem_to_wb_valid;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [3:0]  mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_rf_wdata;
  logic [7:0]  mem_exc;
  logic        mem_load_pending;

  mem_stage_if ex_if ();

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ex                (ex_if),
    .data_sram_rdata   (data_sram_rdata),
    .data_sram_data_ok (data_sram_data_ok),
    .wb_allow_in       (wb_allow_in),
    .flush             (flush),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_valid         (mem_valid),
    .mem_pc            (mem_pc),
    .mem_rf_we         (mem_rf_we),
    .mem_rf_waddr      (mem_rf_waddr),
    .mem_rf_wdata      (mem_rf_wdata),
    .mem_exc           (mem_exc),
    .mem_load_pending  (mem_load_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] addr;
    logic        is_load;
    logic [2:0]  op;
    logic [7:0]  exc;
  } instr_t;

  instr_t      m_ins;
  bit          m_valid;   // stage holds an instruction
  bit          m_wait;    // held load still owed its response
  bit          m_owed;    // a flushed load's response is still in flight
  logic [31:0] m_data;

  task automatic model_reset();
    m_ins   = '0;
    m_valid = 1'b0;
    m_wait  = 1'b0;
    m_owed  = 1'b0;
    m_data  = '0;
  endtask

  function automatic logic [7:0] eff_exc(logic ld, logic [2:0] op,
                                         logic [31:0] addr, logic [7:0] exc);
`ifdef MEM_ALE_CHECK_EN
    if (ld && (((op == 3'd0) && (addr % 4 != 0)) ||
               (((op == 3'd3) || (op == 3'd4)) && (addr % 2 != 0))))
      return exc | 8'h04;
`endif
    return exc;
  endfunction

  function automatic logic [31:0] load_value(logic [31:0] word,
                                             logic [31:0] addr, logic [2:0] op);
    logic [31:0] v;
    case (op)
      3'd1, 3'd2: begin
        v = (word >> (8 * (addr % 4))) & 32'h0000_00FF;
        if (op == 3'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        v = (word >> (16 * ((addr / 2) % 2))) & 32'h0000_FFFF;
        if (op == 3'd3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic bit model_allow();
    return (!m_valid || (!m_wait && wb_allow_in)) && !m_owed;
  endfunction

  // Compare DUT outputs to the model at mid-cycle, then advance the model
  // across the next rising edge.
  task automatic cycle();
    bit          e_allow;
    bit          resp;
    logic [31:0] e_wdata;
    logic [7:0]  eff;
    @(negedge clk);
    e_allow = model_allow();
    check("allow_in",  32'(ex_if.mem_allow_in), 32'(e_allow));
    check("mem_valid", 32'(mem_valid), 32'(m_valid));
    check("to_wb",     32'(mem_to_wb_valid), 32'(m_valid && !m_wait && !flush));
    check("pending",   32'(mem_load_pending), 32'(m_valid && m_wait));
    if (m_valid) begin
      check("pc",    mem_pc, m_ins.pc);
      check("we",    32'(mem_rf_we), 32'(m_ins.we));
      check("waddr", 32'(mem_rf_waddr), 32'(m_ins.waddr));
      check("exc",   32'(mem_exc), 32'(m_ins.exc));
      if (!m_wait && !(m_ins.is_load && m_ins.exc != 8'h00)) begin
        e_wdata = m_ins.is_load ? load_value(m_data, m_ins.addr, m_ins.op)
                                : m_ins.addr;
        check("wdata", mem_rf_wdata, e_wdata);
      end
    end

    resp = data_sram_data_ok;
    if (m_owed && resp) begin
      m_owed = 1'b0;
      resp   = 1'b0;
    end else if (m_valid && m_wait && resp) begin
      m_data = data_sram_rdata;
      m_wait = 1'b0;
      resp   = 1'b0;
    end
    if (flush) begin
      if (m_valid && m_wait) m_owed = 1'b1;
      m_valid = 1'b0;
    end else if (e_allow) begin
      m_valid = ex_if.to_mem_valid;
      if (ex_if.to_mem_valid) begin
        eff   = eff_exc(ex_if.ex_is_load, ex_if.ex_load_op,
                        ex_if.ex_alu_result, ex_if.ex_exc);
        m_ins = '{pc: ex_if.ex_pc, we: ex_if.ex_rf_we, waddr: ex_if.ex_rf_waddr,
                  addr: ex_if.ex_alu_result, is_load: ex_if.ex_is_load,
                  op: ex_if.ex_load_op, exc: eff};
        m_wait = ex_if.ex_is_load && (eff == 8'h00);
        if (m_wait && resp) begin
          m_data = data_sram_rdata;
          m_wait = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit tv, logic [31:0] pc, logic [31:0] addr, bit ld,
                       logic [2:0] op, logic [7:0] exc);
    ex_if.to_mem_valid  = tv;
    ex_if.ex_pc         = pc;
    ex_if.ex_rf_we      = 4'(pc >> 2);
    ex_if.ex_rf_waddr   = 5'(pc >> 6);
    ex_if.ex_alu_result = addr;
    ex_if.ex_is_load    = ld;
    ex_if.ex_load_op    = op;
    ex_if.ex_exc        = exc;
  endtask

  task automatic idle_ex();
    ex_if.to_mem_valid = 1'b0;
  endtask

  // ---------------------------- stimulus -----------------------------
  initial begin
    int          resp_at;
    bit          acc;
    bit          ld;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [7:0]  exc;

    reset             = 1'b1;
    data_sram_rdata   = '0;
    data_sram_data_ok = 1'b0;
    wb_allow_in       = 1'b1;
    flush             = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_valid",   32'(mem_valid), 32'd0);
    check("rst_to_wb",   32'(mem_to_wb_valid), 32'd0);
    check("rst_allow",   32'(ex_if.mem_allow_in), 32'd1);
    check("rst_pc",      mem_pc, 32'd0);
    check("rst_we",      32'(mem_rf_we), 32'd0);
    check("rst_waddr",   32'(mem_rf_waddr), 32'd0);
    check("rst_wdata",   mem_rf_wdata, 32'd0);
    check("rst_exc",     32'(mem_exc), 32'd0);
    check("rst_pending", 32'(mem_load_pending), 32'd0);

    // LB at ...3, response two cycles after accept.
    drive(1'b1, 32'h0000_1000, 32'h0000_1003, 1'b1, 3'd1, 8'h00);
    cycle();
    idle_ex();
    #1 check("lb_pending", 32'(mem_load_pending), 32'd1);
    cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    cycle();
    data_sram_data_ok = 1'b0;
    #1;
    check("lb_wdata", mem_rf_wdata, 32'hFFFF_FF80);
    check("lb_to_wb", 32'(mem_to_wb_valid), 32'd1);
    cycle();
    #1 check("lb_to_wb_once", 32'(mem_to_wb_valid), 32'd0);

    // LHU at ...2: pending stays high until the response.
    drive(1'b1, 32'h0000_2000, 32'h0000_2002, 1'b1, 3'd4, 8'h00);
    cycle();
    idle_ex();
    for (int i = 0; i < 2; i++) begin
      #1 check("lhu_pending", 32'(mem_load_pending), 32'd1);
      cycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_1234;
    #1 check("lhu_pending_ok", 32'(mem_load_pending), 32'd1);
    cycle();
    data_sram_data_ok = 1'b0;
    #1;
    check("lhu_wdata", mem_rf_wdata, 32'h0000_8001);
    check("lhu_pend_clr", 32'(mem_load_pending), 32'd0);
    cycle();

    // Flush in WAIT, response three cycles later is drained.
    drive(1'b1, 32'h0000_3000, 32'h0000_3000, 1'b1, 3'd0, 8'h00);
    cycle();
    idle_ex();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b1, 32'h0000_3100, 32'h0000_0055, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("drain_allow", 32'(ex_if.mem_allow_in), 32'd0);
      check("drain_to_wb", 32'(mem_to_wb_valid), 32'd0);
      cycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1 check("drain_allow_ok", 32'(ex_if.mem_allow_in), 32'd0);
    cycle();
    data_sram_data_ok = 1'b0;
    #1 check("drain_done_allow", 32'(ex_if.mem_allow_in), 32'd1);
    cycle();
    idle_ex();
    #1;
    check("drain_next_pc", mem_pc, 32'h0000_3100);
    check("drain_next_wdata", mem_rf_wdata, 32'h0000_0055);
    cycle();

    // WB backpressure for four cycles holds the stage.
    drive(1'b1, 32'h0000_4000, 32'h1234_5678, 1'b0, 3'd0, 8'h00);
    cycle();
    drive(1'b1, 32'h0000_4004, 32'h0000_9ABC, 1'b0, 3'd0, 8'h00);
    wb_allow_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_to_wb", 32'(mem_to_wb_valid), 32'd1);
      check("bp_pc",    mem_pc, 32'h0000_4000);
      check("bp_wdata", mem_rf_wdata, 32'h1234_5678);
      check("bp_allow", 32'(ex_if.mem_allow_in), 32'd0);
      cycle();
    end
    wb_allow_in = 1'b1;
    #1 check("bp_release_allow", 32'(ex_if.mem_allow_in), 32'd1);
    cycle();
    idle_ex();
    #1 check("bp_next_pc", mem_pc, 32'h0000_4004);
    cycle();

    // Misaligned LW at 0x1002.
    drive(1'b1, 32'h0000_5000, 32'h0000_1002, 1'b1, 3'd0, 8'h00);
    cycle();
    idle_ex();
`ifdef MEM_ALE_CHECK_EN
    #1;
    check("ale_exc",     32'(mem_exc), 32'h04);
    check("ale_pending", 32'(mem_load_pending), 32'd0);
    check("ale_to_wb",   32'(mem_to_wb_valid), 32'd1);
    cycle();
`else
    #1;
    check("noale_exc",     32'(mem_exc), 32'h00);
    check("noale_pending", 32'(mem_load_pending), 32'd1);
    cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    cycle();
    data_sram_data_ok = 1'b0;
    #1;
    check("noale_wdata", mem_rf_wdata, 32'hCAFE_F00D);
    check("noale_to_wb", 32'(mem_to_wb_valid), 32'd1);
    cycle();
`endif

    // Reset while a load waits; the stale response is ignored.
    drive(1'b1, 32'h0000_6000, 32'h0000_5000, 1'b1, 3'd0, 8'h00);
    cycle();
    idle_ex();
    cycle();
    reset = 1'b1;
    #1;
    check("rstw_valid",   32'(mem_valid), 32'd0);
    check("rstw_pending", 32'(mem_load_pending), 32'd0);
    check("rstw_allow",   32'(ex_if.mem_allow_in), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_2222;
    cycle();
    data_sram_data_ok = 1'b0;
    #1;
    check("rstw_stale_valid", 32'(mem_valid), 32'd0);
    check("rstw_stale_allow", 32'(ex_if.mem_allow_in), 32'd1);
    cycle();

    // Randomized traffic with a bench-side SRAM responder.
    resp_at = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush       = ($urandom_range(0, 9) == 0);
      wb_allow_in = ($urandom_range(0, 3) != 0);
      ld   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 4));
      addr = $urandom;
      exc  = ($urandom_range(0, 7) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
      drive(($urandom_range(0, 2) != 0), $urandom, addr, ld, op, exc);
      data_sram_rdata = $urandom;
      acc = model_allow() && ex_if.to_mem_valid && !flush;
      data_sram_data_ok = (resp_at == cyc);
      if (data_sram_data_ok) resp_at = -1;
      if (acc && ld && (eff_exc(ld, op, addr, exc) == 8'h00)) begin
        int lat;
        lat = $urandom_range(0, 3);
        if (lat == 0) data_sram_data_ok = 1'b1;
        else          resp_at = cyc + lat;
      end else if (!data_sram_data_ok && resp_at < 0 && !m_wait && !m_owed &&
                   $urandom_range(0, 7) == 0) begin
        data_sram_data_ok = 1'b1;  // unsolicited response, must be ignored
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
